alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_addsub.sv | 33 +++
 rtl/alu.sv | 117 +++++++++++
 tb/tb_alu.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Opcode definitions shared by the ALU datapath and anything that drives it.
package alu_ops;

  typedef enum logic [3:0] {
    LL_SHIFT_OP = 4'd0,
    LR_SHIFT_OP = 4'd1,
    AL_SHIFT_OP = 4'd2,
    AR_SHIFT_OP = 4'd3,
    NOT_OP      = 4'd4,
    AND_OP      = 4'd5,
    OR_OP       = 4'd6,
    XOR_OP      = 4'd7,
    SUB_OP      = 4'd8,
    ADD_OP      = 4'd9
  } opcode_t;

endpackage

// File: rtl/alu_addsub.sv
// Adder/subtractor: a + b + cin or a - b - cin, with carry/borrow-out
// and two's-complement overflow.
module alu_addsub #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);

  logic [WIDTH:0] res;

  // One extra bit holds the carry (ADD) or the borrow (SUB): a negative
  // difference wraps and sets the top bit.
  always_comb begin
    res   = '0;
    ovf_o = 1'b0;
    if (sub_i) begin
      res   = {1'b0, a_i} - {1'b0, b_i} - {{WIDTH{1'b0}}, cin_i};
      ovf_o = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (res[WIDTH-1] != a_i[WIDTH-1]);
    end else begin
      res   = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};
      ovf_o = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (res[WIDTH-1] != a_i[WIDTH-1]);
    end
    sum_o  = res[WIDTH-1:0];
    cout_o = res[WIDTH];
  end

endmodule

// File: rtl/alu.sv
// Single-cycle-latency ALU: combinational datapath followed by one output
// register stage. Define ALU_SHIFT_CARRY_EN to have shifts report the last
// bit shifted out of a on cout; otherwise shifts drive cout = 0.
module alu
  import alu_ops::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  opcode_t          opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             overflow,
  output logic             negative,
  output logic             zero
);

`ifdef ALU_SHIFT_CARRY_EN
  localparam logic SHIFT_CARRY = 1'b1;
`else
  localparam logic SHIFT_CARRY = 1'b0;
`endif

  logic [WIDTH-1:0] as_sum;
  logic             as_cout;
  logic             as_ovf;

  // Shifts run one bit wider than a so the bit that falls off the end lands
  // in the extra position; oversized shift amounts naturally give zero (or
  // sign fill for the arithmetic right shift).
  logic [WIDTH:0]   ll_ext;
  logic [WIDTH:0]   lr_ext;
  logic [WIDTH:0]   ar_ext;

  logic [WIDTH-1:0] y_d, y_q;
  logic             cout_d, cout_q;
  logic             ovf_d, ovf_q;

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a_i    (a),
    .b_i    (b),
    .cin_i  (cin),
    .sub_i  (opcode == SUB_OP),
    .sum_o  (as_sum),
    .cout_o (as_cout),
    .ovf_o  (as_ovf)
  );

  // Extended shift results; carry-out sits in bit WIDTH (left) or bit 0 (right).
  always_comb begin
    ll_ext = {1'b0, a} << b;
    lr_ext = {a, 1'b0} >> b;
    ar_ext = $signed({a, 1'b0}) >>> b;
  end

  // Result select; unused opcodes fall through to all-zero.
  always_comb begin
    y_d    = '0;
    cout_d = 1'b0;
    ovf_d  = 1'b0;
    case (opcode)
      LL_SHIFT_OP, AL_SHIFT_OP: begin
        y_d    = ll_ext[WIDTH-1:0];
        cout_d = SHIFT_CARRY & ll_ext[WIDTH];
      end
      LR_SHIFT_OP: begin
        y_d    = lr_ext[WIDTH:1];
        cout_d = SHIFT_CARRY & lr_ext[0];
      end
      AR_SHIFT_OP: begin
        y_d    = ar_ext[WIDTH:1];
        cout_d = SHIFT_CARRY & ar_ext[0];
      end
      NOT_OP: y_d = ~a;
      AND_OP: y_d = a & b;
      OR_OP:  y_d = a | b;
      XOR_OP: y_d = a ^ b;
      SUB_OP, ADD_OP: begin
        y_d    = as_sum;
        cout_d = as_cout;
        ovf_d  = as_ovf;
      end
      default: begin
        y_d    = '0;
        cout_d = 1'b0;
        ovf_d  = 1'b0;
      end
    endcase
  end

  // Output register stage; reset wins over any operation presented with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      y_q    <= y_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
    end
  end

  // Flags derived from the registered result.
  always_comb begin
    y        = y_q;
    cout     = cout_q;
    overflow = ovf_q;
    negative = y_q[WIDTH-1];
    zero     = (y_q == '0);
  end

endmodule

// File: tb/tb_alu.sv
// Directed and random checks of the ALU against an integer reference model.
module tb_alu;
  import alu_ops::*;

  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;

`ifdef ALU_SHIFT_CARRY_EN
  localparam bit SC_EN = 1'b1;
`else
  localparam bit SC_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  opcode_t       opcode;
  logic [W-1:0]  a, b;
  logic          cin;
  logic [W-1:0]  y;
  logic          cout, overflow, negative, zero;

  int errors = 0;
  int checks = 0;

  alu #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .opcode   (opcode),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .y        (y),
    .cout     (cout),
    .overflow (overflow),
    .negative (negative),
    .zero     (zero)
  );

  // clock
  always #5 clk = ~clk;

  // Reference model on plain integers; returns {overflow, cout, y}.
  function automatic logic [W+1:0] model(input int op, input int av, input int bv, input int ci);
    int yv, cv, vv, sgn, sv, sa, sb, sy;
    yv = 0; cv = 0; vv = 0;
    sgn = (av >> (W-1)) & 1;
    case (op)
      0, 2: begin
        yv = (bv >= W) ? 0 : ((av << bv) & MASK);
        cv = (bv == 0 || bv > W) ? 0 : ((av >> (W - bv)) & 1);
      end
      1: begin
        yv = (bv >= W) ? 0 : (av >> bv);
        cv = (bv == 0 || bv > W) ? 0 : ((av >> (bv - 1)) & 1);
      end
      3: begin
        sv = sgn ? av - (1 << W) : av;
        yv = (bv >= W) ? (sgn ? MASK : 0) : ((sv >>> bv) & MASK);
        cv = (bv == 0) ? 0 : (bv > W) ? sgn : ((av >> (bv - 1)) & 1);
      end
      4: yv = (~av) & MASK;
      5: yv = av & bv;
      6: yv = av | bv;
      7: yv = av ^ bv;
      8: begin
        yv = (av - bv - ci) & MASK;
        cv = (av < bv + ci) ? 1 : 0;
        sa = sgn; sb = (bv >> (W-1)) & 1; sy = (yv >> (W-1)) & 1;
        vv = (sa != sb && sy != sa) ? 1 : 0;
      end
      9: begin
        yv = (av + bv + ci) & MASK;
        cv = ((av + bv + ci) >> W) & 1;
        sa = sgn; sb = (bv >> (W-1)) & 1; sy = (yv >> (W-1)) & 1;
        vv = (sa == sb && sy != sa) ? 1 : 0;
      end
      default: begin yv = 0; cv = 0; vv = 0; end
    endcase
    if (op <= 3 && !SC_EN) cv = 0;
    return {vv[0], cv[0], yv[W-1:0]};
  endfunction

  // Compare all five outputs with expected values.
  task automatic check_outputs(input string tag, input logic [W-1:0] ey, input logic ec, input logic ev);
    logic en, ez;
    en = ey[W-1];
    ez = (ey == '0);
    checks++;
    assert (y === ey) else begin errors++; $error("FAIL %s y: got %0b expected %0b", tag, y, ey); end
    checks++;
    assert (cout === ec) else begin errors++; $error("FAIL %s cout: got %0b expected %0b", tag, cout, ec); end
    checks++;
    assert (overflow === ev) else begin errors++; $error("FAIL %s overflow: got %0b expected %0b", tag, overflow, ev); end
    checks++;
    assert (negative === en) else begin errors++; $error("FAIL %s negative: got %0b expected %0b", tag, negative, en); end
    checks++;
    assert (zero === ez) else begin errors++; $error("FAIL %s zero: got %0b expected %0b", tag, zero, ez); end
  endtask

  // Drive one operation at the falling edge, check one rising edge later.
  task automatic do_op(input string tag, input int op, input int av, input int bv, input int ci);
    logic [W+1:0] exp_v;
    @(negedge clk);
    opcode = opcode_t'(op[3:0]);
    a      = av[W-1:0];
    b      = bv[W-1:0];
    cin    = ci[0];
    exp_v  = model(op, av, bv, ci);
    @(posedge clk);
    #1;
    check_outputs(tag, exp_v[W-1:0], exp_v[W], exp_v[W+1]);
  endtask

  initial begin
    logic [W+1:0] prev;
    int op_r, a_r, b_r, c_r;

    rst = 1'b1; opcode = ADD_OP; a = 4'd3; b = 4'd4; cin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", 4'b0000, 1'b0, 1'b0);

    @(negedge clk);
    rst = 1'b0;

    // Directed vectors with literal expectations
    do_op("ll_0001_3", 0, 4'b0001, 3, 0);
    checks++;
    assert (y === 4'b1000) else begin errors++; $error("FAIL ll_lit y: got %0b expected 1000", y); end
    do_op("lr_1011_1", 1, 4'b1011, 1, 0);
    checks++;
    assert (y === 4'b0101) else begin errors++; $error("FAIL lr_lit y: got %0b expected 0101", y); end
    do_op("ar_1001_1", 3, 4'b1001, 1, 0);
    checks++;
    assert (y === 4'b1100 && negative === 1'b1) else begin errors++; $error("FAIL ar_lit y/neg: got %0b/%0b expected 1100/1", y, negative); end
    do_op("ll_1000_1", 0, 4'b1000, 1, 0);
    checks++;
    assert (cout === SC_EN) else begin errors++; $error("FAIL shift_cout_cfg: got %0b expected %0b", cout, SC_EN); end
    do_op("not", 4, 4'b1010, 0, 0);
    do_op("and", 5, 4'b1010, 4'b0111, 0);
    do_op("or",  6, 4'b1000, 4'b0100, 0);
    do_op("xor", 7, 4'b1010, 4'b1010, 0);
    do_op("add_ovf", 9, 4'b0100, 4'b0110, 1);
    checks++;
    assert (y === 4'b1011 && cout === 1'b0 && overflow === 1'b1) else begin errors++; $error("FAIL add_lit: got %0b/%0b/%0b expected 1011/0/1", y, cout, overflow); end
    do_op("add_carry", 9, 4'b1111, 4'b0001, 0);
    do_op("sub_ovf", 8, 4'b1000, 4'b0011, 1);
    checks++;
    assert (y === 4'b0100 && cout === 1'b0 && overflow === 1'b1) else begin errors++; $error("FAIL sub_lit: got %0b/%0b/%0b expected 0100/0/1", y, cout, overflow); end
    do_op("sub_borrow", 8, 4'b0001, 4'b0010, 0);
    // Shift boundaries: b = WIDTH and b > WIDTH
    do_op("ll_bW",   0, 4'b0111, 4, 0);
    do_op("lr_bW",   1, 4'b1001, 4, 0);
    do_op("ar_bW",   3, 4'b1001, 4, 0);
    do_op("ar_big",  3, 4'b1010, 9, 0);
    do_op("al_big",  2, 4'b1111, 7, 0);
    do_op("lr_b0",   1, 4'b1111, 0, 0);
    do_op("unused",  12, 4'b1111, 4'b1111, 1);

    // Mid-stream reset discards the operation presented with it
    @(negedge clk);
    rst = 1'b1; opcode = ADD_OP; a = 4'b1111; b = 4'b1111; cin = 1'b1;
    @(posedge clk);
    #1;
    check_outputs("mid_reset", 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Random back-to-back operations
    for (int i = 0; i < 300; i++) begin
      op_r = $urandom_range(0, 15);
      a_r  = $urandom_range(0, MASK);
      b_r  = $urandom_range(0, MASK);
      c_r  = $urandom_range(0, 1);
      do_op("random", op_r, a_r, b_r, c_r);
    end

    // Output holds its value until the next rising edge after a change
    do_op("hold_a", 9, 4'b0011, 4'b0001, 0);
    prev = model(9, 3, 1, 0);
    @(negedge clk);
    opcode = NOT_OP; a = 4'b0000;
    #1;
    checks++;
    assert (y === prev[W-1:0]) else begin errors++; $error("FAIL latency_hold y: got %0b expected %0b", y, prev[W-1:0]); end
    @(posedge clk);
    #1;
    checks++;
    assert (y === 4'b1111) else begin errors++; $error("FAIL latency_next y: got %0b expected 1111", y); end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
